aes_req_scheduler: RTL and testbench

//  Shares one fully pipelined aes_128 core between NUM_REQ requesters. Each requester

---
 rtl/aes_req_scheduler.sv | 105 ++++++++++
 tb/tb_aes_req_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_scheduler.sv
// Round-robin front end that shares one fully pipelined aes_128 core among NUM_REQ requesters.
// A tag pipe matched to the core latency returns each ciphertext with its requester id.
module aes_req_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 1,
    parameter int AES_LATENCY = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_state,
    input  logic [NUM_REQ*128-1:0]   req_key,
    output logic [127:0]             core_state,
    output logic [127:0]             core_key,
    input  logic [127:0]             core_out,
    output logic                     res_valid,
    output logic [ID_W-1:0]          res_id,
    output logic [127:0]             res_data,
    output logic                     busy
);

    localparam int CNT_W = $clog2(AES_LATENCY + 2);

    logic [ID_W-1:0]  rr_ptr;
    logic             accept;
    logic [ID_W-1:0]  grant_id;
    logic [CNT_W-1:0] inflight;

    logic             tag_vld_p [0:AES_LATENCY];
    logic [ID_W-1:0]  tag_id_p  [0:AES_LATENCY];

    // Scan upward from the requester after the last winner; cand wraps at NUM_REQ,
    // so ids outside 0..NUM_REQ-1 are never visited.
    always_comb begin
        logic [ID_W-1:0] cand;
        accept    = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        cand      = rr_ptr;
        if (!rst && !hold) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
                if (!accept && req_valid[cand]) begin
                    accept   = 1'b1;
                    grant_id = cand;
                end
            end
            if (accept) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    // Issue stage: registered core inputs and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            core_state <= '0;
            core_key   <= '0;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            core_state <= req_state[int'(grant_id)*128 +: 128];
            core_key   <= req_key[int'(grant_id)*128 +: 128];
            rr_ptr     <= grant_id;
        end
    end

    // Tag pipe: stage 0 loads at the accept edge, last stage lines up with core_out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= AES_LATENCY; s++) begin
                tag_vld_p[s] <= 1'b0;
                tag_id_p[s]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= accept;
            tag_id_p[0]  <= grant_id;
            for (int s = 1; s <= AES_LATENCY; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end
        end
    end

    assign res_valid = tag_vld_p[AES_LATENCY];
    assign res_id    = tag_id_p[AES_LATENCY];
    assign res_data  = core_out;

    // Outstanding-operation count; simultaneous accept and retire cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({accept, res_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler: a stand-in aes_128 core, a transaction-level model of the
// scheduler checked every cycle, and directed scenarios with literal expectations.
module tb_aes_req_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int LAT     = 20;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hold;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_state;
    logic [NUM_REQ*128-1:0] req_key;
    logic [127:0]           core_state;
    logic [127:0]           core_key;
    logic [127:0]           core_out;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [127:0]           res_data;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    aes_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .AES_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_key(req_key), .core_state(core_state),
        .core_key(core_key), .core_out(core_out), .res_valid(res_valid),
        .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the real answer for the reference vector, a cheap mix otherwise.
    function automatic logic [127:0] aes_ref(input logic [127:0] s, input logic [127:0] k);
        if (s == PT && k == KEY) return CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Core stand-in: out reflects the input that was present LAT edges earlier.
    logic [127:0] core_pipe [0:LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= aes_ref(core_state, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int due; int id; logic [127:0] data; } exp_t;
    typedef struct { int cyc; int id; logic [127:0] data; } ev_t;

    exp_t         pend[$];
    ev_t          grant_log[$];
    ev_t          res_log[$];
    int           cyc = 0;
    int           m_ptr = NUM_REQ - 1;
    bit           m_live = 1'b0;
    logic [127:0] m_state = '0;
    logic [127:0] m_key = '0;
    int           max_dut = 0;
    int           max_model = 0;
    int           last_busy_cyc = -1;

    // Model of the scheduler at transaction level, compared on every falling edge.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        bit                 acc;
        bit                 exp_res;
        int                 gid;
        int                 c;
        cyc++;
        exp_ready = '0;
        acc       = 1'b0;
        gid       = 0;
        exp_res   = 1'b0;
        if (!rst && !hold) begin
            for (int n = 1; n <= NUM_REQ; n++) begin
                c = (m_ptr + n) % NUM_REQ;
                if (!acc && req_valid[c]) begin
                    acc = 1'b1;
                    gid = c;
                end
            end
        end
        if (acc) exp_ready[gid] = 1'b1;
        if (m_live) begin
            exp_res = (pend.size() > 0) && (pend[0].due == cyc);
            chk("req_ready", 128'(req_ready), 128'(exp_ready));
            chk("res_valid", 128'(res_valid), 128'(exp_res));
            if (exp_res && res_valid) begin
                chk("res_id", 128'(res_id), 128'(pend[0].id));
                chk("res_data", res_data, pend[0].data);
            end
            chk("busy", 128'(busy), 128'(pend.size() != 0));
            chk("inflight", 128'(dut.inflight), 128'(pend.size()));
            chk("core_state", core_state, m_state);
            chk("core_key", core_key, m_key);
            if (int'(dut.inflight) > max_dut) max_dut = int'(dut.inflight);
            if (pend.size() > max_model) max_model = pend.size();
            if (busy) last_busy_cyc = cyc;
            if (res_valid) res_log.push_back('{cyc, int'(res_id), res_data});
            if (acc) grant_log.push_back('{cyc, gid, '0});
        end
        if (exp_res) void'(pend.pop_front());
        if (rst) begin
            pend.delete();
            m_ptr   = NUM_REQ - 1;
            m_state = '0;
            m_key   = '0;
            m_live  = 1'b1;
        end else if (acc) begin
            m_state = req_state[gid*128 +: 128];
            m_key   = req_key[gid*128 +: 128];
            pend.push_back('{cyc + LAT + 1, gid, aes_ref(m_state, m_key)});
            m_ptr = gid;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_state = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_state = '0; req_key = '0;
        cycles(2);
        rst = 1'b0;
        #1;
        chk("reset_core_state", core_state, 128'h0);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_res_valid", 128'(res_valid), 128'h0);
        chk("reset_res_id", 128'(res_id), 128'h0);

        // hold blocks everything, release grants req0 first
        hold = 1'b1; req_valid = 2'b11; scramble();
        cycles(3);
        chk("hold_ready", 128'(req_ready), 128'h0);
        chk("hold_core_state", core_state, 128'h0);
        hold = 1'b0;
        #1;
        chk("release_ready", 128'(req_ready), 128'h1);
        cycles(1);
        req_valid = '0;
        cycles(30);

        // single op with the reference vector
        grant_log.delete(); res_log.delete();
        req_state[127:0] = PT; req_key[127:0] = KEY; req_valid = 2'b01;
        cycles(1);
        req_valid = '0;
        cycles(30);
        chk("single_grants", 128'(grant_log.size()), 128'd1);
        chk("single_results", 128'(res_log.size()), 128'd1);
        if (grant_log.size() == 1 && res_log.size() == 1) begin
            chk("single_latency", 128'(res_log[0].cyc - grant_log[0].cyc), 128'd21);
            chk("single_id", 128'(res_log[0].id), 128'd0);
            chk("single_data", res_log[0].data, CT);
        end

        // req1 alone, every cycle
        res_log.delete();
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin scramble(); cycles(1); end
        req_valid = '0;
        cycles(30);
        chk("solo_results", 128'(res_log.size()), 128'd5);
        for (int i = 0; i < res_log.size(); i++) begin
            chk("solo_id", 128'(res_log[i].id), 128'd1);
            chk("solo_spacing", 128'(res_log[i].cyc - res_log[0].cyc), 128'(i));
        end

        // both requesters for 8 cycles
        res_log.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin scramble(); cycles(1); end
        req_valid = '0;
        cycles(30);
        chk("alt_results", 128'(res_log.size()), 128'd8);
        for (int i = 0; i < res_log.size(); i++) begin
            chk("alt_id", 128'(res_log[i].id), 128'(i % 2));
            chk("alt_spacing", 128'(res_log[i].cyc - res_log[0].cyc), 128'(i));
        end
        if (res_log.size() > 0)
            chk("alt_busy_fall", 128'(last_busy_cyc), 128'(res_log[res_log.size()-1].cyc));

        // reset while three ops are in flight
        grant_log.delete();
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin scramble(); cycles(1); end
        req_valid = '0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        res_log.delete();
        cycles(30);
        chk("rst_grants", 128'(grant_log.size()), 128'd3);
        chk("rst_no_results", 128'(res_log.size()), 128'd0);
        chk("rst_busy", 128'(busy), 128'h0);

        // sustained stream: accept and retire overlap
        max_dut = 0; max_model = 0; res_log.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 25; i++) begin scramble(); cycles(1); end
        req_valid = '0;
        cycles(30);
        chk("stream_results", 128'(res_log.size()), 128'd25);
        chk("stream_inflight_max", 128'(max_dut), 128'd21);
        chk("stream_model_max", 128'(max_model), 128'd21);
        chk("stream_busy_end", 128'(busy), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
